// File: rtl/prog_loader_pkg.sv
// Shared types and default widths for the nibble-stream program loader.
package prog_loader_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int NIB_W_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HI   = 3'd1,
        ST_LO   = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Host/nibble-stream/memory-write bundle of the program loader.
interface prog_loader_if #(
    parameter int ADDR_W = prog_loader_pkg::ADDR_W_DEF,
    parameter int NIB_W  = prog_loader_pkg::NIB_W_DEF
);

    logic                 load;
    logic [ADDR_W-1:0]    data;
    logic [ADDR_W-1:0]    length;
    logic [NIB_W-1:0]     nib_in;
    logic                 nib_valid;
    logic                 nib_ready;
    logic [ADDR_W-1:0]    mem_addr;
    logic [2*NIB_W-1:0]   mem_wdata;
    logic                 mem_we;
    logic                 busy;
    logic                 done;

    // Host / stream source side.
    modport master (
        output load, data, length, nib_in, nib_valid,
        input  nib_ready, mem_addr, mem_wdata, mem_we, busy, done
    );

    // Loader side.
    modport slave (
        input  load, data, length, nib_in, nib_valid,
        output nib_ready, mem_addr, mem_wdata, mem_we, busy, done
    );

endinterface

// File: rtl/prog_loader_addr_counter.sv
// Loadable up-counter for the program-memory write address; wraps naturally at 2^ADDR_W.
module addr_counter #(
    parameter int ADDR_W = prog_loader_pkg::ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              load,
    input  logic              enable,
    input  logic [ADDR_W-1:0] data,
    output logic [ADDR_W-1:0] Q
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            Q <= '0;
        end else if (load) begin
            Q <= data;
        end else if (enable) begin
            Q <= Q + 1'b1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Assembles pairs of nibbles into bytes and writes them to consecutive program-memory addresses.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NIB_W  = NIB_W_DEF
) (
    input  logic         Clk,
    input  logic         reset,
    prog_loader_if.slave bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [NIB_W-1:0]  hi_q, hi_d;
    logic [NIB_W-1:0]  lo_q, lo_d;
    logic [ADDR_W-1:0] addr;
    logic              addr_load;
    logic              addr_en;
    logic              nib_ready;
    logic              nib_xfer;
    logic              mem_we;

    addr_counter #(.ADDR_W(ADDR_W)) u_addr (
        .Clk    (Clk),
        .reset  (reset),
        .load   (addr_load),
        .enable (addr_en),
        .data   (bus.data),
        .Q      (addr)
    );

    assign nib_ready = (state_q == ST_HI) || (state_q == ST_LO);
    assign nib_xfer  = bus.nib_valid && nib_ready;
    assign mem_we    = (state_q == ST_WR);

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        rem_d     = rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        addr_load = 1'b0;
        addr_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    addr_load = 1'b1;
                    rem_d     = bus.length;
                    state_d   = (bus.length != '0) ? ST_HI : ST_DONE;
                end
            end
            ST_HI: begin
                if (nib_xfer) begin
                    hi_d    = bus.nib_in;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (nib_xfer) begin
                    lo_d    = bus.nib_in;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                addr_en = 1'b1;
                rem_d   = rem_q - 1'b1;
                // Decision uses the pre-decrement value: one byte left means this was the last.
                state_d = (rem_q == ADDR_W'(1)) ? ST_DONE : ST_HI;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.nib_ready = nib_ready;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = mem_we ? {hi_q, lo_q} : '0;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: inputs change and outputs are sampled on the falling edge.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic Clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   we_cnt   = 0;
    int   done_cnt = 0;

    always #5 Clk = ~Clk;

    prog_loader_if #(.ADDR_W(12), .NIB_W(4)) bus ();

    prog_loader #(.ADDR_W(12), .NIB_W(4)) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(negedge Clk) begin
        if (bus.mem_we === 1'b1) we_cnt++;
        if (bus.done === 1'b1) done_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic start_load(input logic [11:0] addr, input logic [11:0] len);
        bus.load   = 1'b1;
        bus.data   = addr;
        bus.length = len;
        @(negedge Clk);
        bus.load   = 1'b0;
    endtask

    task automatic send_nib(input logic [3:0] n);
        int waited = 0;
        while (bus.nib_ready !== 1'b1 && waited < 20) begin
            @(negedge Clk);
            waited++;
        end
        check("nib_ready_wait", 32'(bus.nib_ready), 32'd1);
        bus.nib_in    = n;
        bus.nib_valid = 1'b1;
        @(negedge Clk);
        bus.nib_valid = 1'b0;
    endtask

    task automatic expect_write(input logic [11:0] addr, input logic [7:0] wdata);
        check("wr_we",    32'(bus.mem_we),    32'd1);
        check("wr_addr",  32'(bus.mem_addr),  32'(addr));
        check("wr_wdata", 32'(bus.mem_wdata), 32'(wdata));
        @(negedge Clk);
        check("post_wr_we",    32'(bus.mem_we),    32'd0);
        check("post_wr_wdata", 32'(bus.mem_wdata), 32'd0);
    endtask

    initial begin
        bus.load      = 1'b0;
        bus.data      = '0;
        bus.length    = '0;
        bus.nib_in    = '0;
        bus.nib_valid = 1'b0;

        // Reset held for three cycles, then idle outputs.
        repeat (3) @(negedge Clk);
        check("rst_busy",  32'(bus.busy),      32'd0);
        check("rst_ready", 32'(bus.nib_ready), 32'd0);
        check("rst_we",    32'(bus.mem_we),    32'd0);
        reset = 1'b1;
        @(negedge Clk);
        check("idle_state", 32'(dut.state_q),   32'(ST_IDLE));
        check("idle_busy",  32'(bus.busy),      32'd0);
        check("idle_done",  32'(bus.done),      32'd0);
        check("idle_we",    32'(bus.mem_we),    32'd0);
        check("idle_ready", 32'(bus.nib_ready), 32'd0);
        check("idle_addr",  32'(bus.mem_addr),  32'd0);
        check("idle_wdata", 32'(bus.mem_wdata), 32'd0);

        // Two-byte write at 0x032.
        start_load(12'h032, 12'd2);
        check("t2_state_hi", 32'(dut.state_q),  32'(ST_HI));
        check("t2_busy",     32'(bus.busy),     32'd1);
        check("t2_addr",     32'(bus.mem_addr), 32'h032);
        send_nib(4'h5);
        send_nib(4'hA);
        expect_write(12'h032, 8'h5A);
        send_nib(4'h3);
        send_nib(4'hC);
        expect_write(12'h033, 8'h3C);
        check("t2_done",      32'(bus.done), 32'd1);
        check("t2_busy_done", 32'(bus.busy), 32'd1);
        @(negedge Clk);
        check("t2_done_off", 32'(bus.done),    32'd0);
        check("t2_busy_off", 32'(bus.busy),    32'd0);
        check("t2_idle",     32'(dut.state_q), 32'(ST_IDLE));
        check("t2_we_cnt",   32'(we_cnt),      32'd2);
        check("t2_done_cnt", 32'(done_cnt),    32'd1);

        // Address wrap with four stalled cycles in LO.
        start_load(12'hFFF, 12'd2);
        send_nib(4'h1);
        repeat (4) begin
            check("bp_state", 32'(dut.state_q), 32'(ST_LO));
            check("bp_we",    32'(bus.mem_we),  32'd0);
            @(negedge Clk);
        end
        check("bp_state_end", 32'(dut.state_q), 32'(ST_LO));
        send_nib(4'h2);
        expect_write(12'hFFF, 8'h12);
        send_nib(4'h3);
        send_nib(4'h4);
        expect_write(12'h000, 8'h34);
        check("wrap_done", 32'(bus.done), 32'd1);
        @(negedge Clk);
        check("wrap_we_cnt", 32'(we_cnt), 32'd4);

        // Zero length, plus a load presented while in DONE.
        start_load(12'h055, 12'd0);
        check("zl_done", 32'(bus.done),     32'd1);
        check("zl_we",   32'(bus.mem_we),   32'd0);
        check("zl_addr", 32'(bus.mem_addr), 32'h055);
        bus.load   = 1'b1;
        bus.data   = 12'h300;
        bus.length = 12'd1;
        @(negedge Clk);
        bus.load   = 1'b0;
        check("dl_state", 32'(dut.state_q),  32'(ST_IDLE));
        check("dl_busy",  32'(bus.busy),     32'd0);
        check("dl_done",  32'(bus.done),     32'd0);
        check("dl_addr",  32'(bus.mem_addr), 32'h055);
        @(negedge Clk);
        check("dl_still_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // Load pulsed during HI is ignored: address and byte count keep their original values.
        start_load(12'h100, 12'd1);
        bus.load   = 1'b1;
        bus.data   = 12'h200;
        bus.length = 12'd5;
        @(negedge Clk);
        bus.load   = 1'b0;
        check("il_state", 32'(dut.state_q),  32'(ST_HI));
        check("il_addr",  32'(bus.mem_addr), 32'h100);
        send_nib(4'h7);
        send_nib(4'hE);
        expect_write(12'h100, 8'h7E);
        check("il_done", 32'(bus.done), 32'd1);
        @(negedge Clk);
        check("il_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // Reset after only the high nibble.
        start_load(12'h010, 12'd1);
        send_nib(4'h9);
        check("rm_state_lo", 32'(dut.state_q), 32'(ST_LO));
        #1 reset = 1'b0;
        #1;
        check("rm_state", 32'(dut.state_q),   32'(ST_IDLE));
        check("rm_busy",  32'(bus.busy),      32'd0);
        check("rm_ready", 32'(bus.nib_ready), 32'd0);
        check("rm_addr",  32'(bus.mem_addr),  32'd0);
        check("rm_we",    32'(bus.mem_we),    32'd0);
        check("rm_hi",    32'(dut.hi_q),      32'd0);
        repeat (2) @(negedge Clk);
        reset = 1'b1;
        repeat (3) @(negedge Clk);
        check("rm_idle_after", 32'(dut.state_q), 32'(ST_IDLE));
        check("rm_busy_after", 32'(bus.busy),    32'd0);
        check("total_we_cnt",   32'(we_cnt),   32'd5);
        check("total_done_cnt", 32'(done_cnt), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 12, sets the width of the program-memory address.
REQ-002 Parameter NIB_W, default 4, sets the nibble width; the byte width is 2*NIB_W.
REQ-003 Clk  input  1  is the single clock; all state changes on the rising edge.
REQ-004 reset  input  1  is the asynchronous, active-low reset.
REQ-005 load  input  1  is a one-cycle start strobe.
REQ-006 data  input  ADDR_W  is the start address, sampled on load.
REQ-007 length  input  ADDR_W  is the byte count, sampled on load.
REQ-008 nib_in  input  NIB_W  is the incoming nibble.
REQ-009 nib_valid  input  1  asserts that nib_in holds a valid nibble.
REQ-010 nib_ready  output  1  asserts that the loader accepts a nibble this cycle.
REQ-011 mem_addr  output  ADDR_W  is the write address.
REQ-012 mem_wdata  output  2*NIB_W  is the write byte, {high nibble, low nibble}.
REQ-013 mem_we  output  1  is the write strobe, one cycle per byte.
REQ-014 busy  output  1  is high from the load acceptance until DONE exits.
REQ-015 done  output  1  is a one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have exactly five states: IDLE, HI, LO, WR, DONE.
REQ-017 In IDLE, load=1 SHALL capture data into the address counter and length into the remaining-count register.
- Next state on that load: HI if length!=0; DONE if length==0.
REQ-018 A load pulse outside IDLE SHALL be ignored.
REQ-019 nib_ready SHALL be 1 only in HI and LO; a nibble transfers on the edge where nib_valid&&nib_ready.
REQ-020 HI SHALL store the transferred nibble as the high nibble and advance to LO; with no transfer it holds HI.
REQ-021 LO SHALL store the transferred nibble as the low nibble and advance to WR; with no transfer it holds LO.
REQ-022 WR SHALL assert mem_we for exactly one cycle.
- In that cycle: mem_addr = current address; mem_wdata = {high, low}.
- Latency from the low-nibble transfer edge to mem_we high: 1 cycle.
REQ-023 On exit from WR, the address SHALL increment modulo 2^ADDR_W, so 0xFFF wraps to 0x000.
REQ-024 On exit from WR, remaining SHALL decrement; if the new value is 0 the next state is DONE, otherwise HI.
REQ-025 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-026 busy SHALL be 1 in HI, LO, WR and DONE, and 0 in IDLE.
REQ-027 mem_we SHALL be 0 in every state other than WR.
REQ-028 mem_wdata SHALL be 0 whenever mem_we=0.
REQ-029 mem_addr SHALL always show the current address counter value.
REQ-030 A load=1 in the same cycle as the DONE state SHALL be ignored; the next load is accepted from IDLE.

Reset
REQ-031 reset=0 SHALL asynchronously force the following, regardless of Clk:
- state to IDLE;
- address, remaining and nibble registers to 0;
- nib_ready, mem_we, busy, done to 0;
- mem_addr and mem_wdata to 0.
REQ-032 Reset asserted mid-transfer SHALL abandon the partial byte with no write; after release the block waits in IDLE for a new load.

Structure
REQ-033 Package prog_loader_pkg SHALL hold the state enumeration and the ADDR_W/NIB_W default constants.
REQ-034 The address register SHALL be a sub-module addr_counter with these ports: Clk, reset, load, enable, data, Q.
- Behaviour: loadable, wrapping, counting up.
REQ-035 The FSM, nibble registers and remaining counter SHALL live in prog_loader.

Verification
REQ-036 Reset and idle: reset=0 for 3 cycles, then release -> all outputs 0, nib_ready=0, state IDLE.
REQ-037 Two-byte write:
- Stimulus: data=0x032, length=2, load; nibbles 0x5,0xA,0x3,0xC.
- Required: mem_we at 0x032 with 0x5A, then at 0x033 with 0x3C; done pulses once; busy falls after done.
REQ-038 Backpressure: nib_valid held 0 for 4 cycles in LO -> state holds LO, no mem_we; the write proceeds once the nibble arrives.
REQ-039 Address wrap: data=0xFFF, length=2, nibbles 0x1,0x2,0x3,0x4 -> writes 0x12@0xFFF, then 0x34@0x000.
REQ-040 Zero length and ignored load:
- length=0, load -> done one cycle later, no mem_we.
- load pulsed during HI -> ignored; address unchanged.
REQ-041 Reset mid-op: reset=0 after the high nibble only -> no mem_we; after release IDLE, busy=0.
